// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, framing helpers and the
// safe clog2 macro used for counter widths.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package uart_pkg;

    typedef enum logic [2:0] {
        e_reset      = 3'd0,
        e_idle       = 3'd1,
        e_start_bit  = 3'd2,
        e_data_bits  = 3'd3,
        e_parity_bit = 3'd4,
        e_stop_bit   = 3'd5
    } uart_tx_state_e;

    // Clock cycles in one complete frame, start bit through last stop bit.
    function automatic int uart_frame_cycles(input int clk_per_bit,
                                             input int data_bits,
                                             input int parity_bit,
                                             input int stop_bits);
        return (1 + data_bits + parity_bit + stop_bits) * clk_per_bit;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: down-counter that pulses bit_done_o on its last cycle of
// every clk_per_bit_p period; restart_i begins a fresh period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int clk_per_bit_p = 10416
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic restart_i,
    output logic bit_done_o
);

    localparam int cnt_width_lp = `BSG_SAFE_CLOG2(clk_per_bit_p + 1);
    localparam logic [cnt_width_lp-1:0] reload_lp = cnt_width_lp'(clk_per_bit_p - 1);

    logic [cnt_width_lp-1:0] cnt_r;

    always_ff @(posedge clk_i) begin
        if (reset_i || restart_i || bit_done_o)
            cnt_r <= reload_lp;
        else
            cnt_r <= cnt_r - cnt_width_lp'(1);
    end

    assign bit_done_o = (cnt_r == '0);

endmodule

// File: rtl/uart_tx.sv
// Serializing UART transmitter, LSB first, registered line output.
// Optional line-break input enabled with the UART_TX_BREAK_EN macro.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clk_per_bit_p = 10416,
    parameter int data_bits_p   = 8,
    parameter int parity_bit_p  = 0,
    parameter int parity_odd_p  = 0,
    parameter int stop_bits_p   = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   tx_v_i,
    input  logic [data_bits_p-1:0] tx_i,
    output logic                   tx_ready_o,
    output logic                   tx_o
`ifdef UART_TX_BREAK_EN
   ,input  logic                   break_i
`endif
);

    localparam int data_cnt_width_lp = `BSG_SAFE_CLOG2(data_bits_p);
    localparam logic [data_cnt_width_lp-1:0] last_data_lp = data_cnt_width_lp'(data_bits_p - 1);

    uart_tx_state_e state_r, state_n;
    logic [data_bits_p-1:0]       shift_r, shift_n;
    logic [data_cnt_width_lp-1:0] data_cnt_r, data_cnt_n;
    logic parity_r, parity_n;
    logic stop_cnt_r, stop_cnt_n;
    logic tx_r, tx_n;
    logic restart;
    logic bit_done;
    logic brk;
    logic stop_last;

`ifdef UART_TX_BREAK_EN
    assign brk = break_i;
`else
    assign brk = 1'b0;
`endif

    uart_bit_timer #(
        .clk_per_bit_p(clk_per_bit_p)
    ) u_bit_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .restart_i  (restart),
        .bit_done_o (bit_done)
    );

    assign tx_ready_o = (state_r == e_idle) && !brk;
    assign stop_last  = (stop_bits_p == 1) || stop_cnt_r;
    assign tx_o       = tx_r;

    // tx_n is the line value for the state being entered, so tx_o is registered
    // yet changes in the same cycle as the state.
    always_comb begin
        state_n    = state_r;
        shift_n    = shift_r;
        data_cnt_n = data_cnt_r;
        parity_n   = parity_r;
        stop_cnt_n = stop_cnt_r;
        tx_n       = tx_r;
        restart    = 1'b0;

        case (state_r)
            e_reset: begin
                state_n = e_idle;
                tx_n    = 1'b1;
            end
            e_idle: begin
                tx_n = !brk;
                if (tx_v_i && tx_ready_o) begin
                    state_n    = e_start_bit;
                    shift_n    = tx_i;
                    parity_n   = (^tx_i) ^ (parity_odd_p != 0);
                    data_cnt_n = '0;
                    stop_cnt_n = 1'b0;
                    restart    = 1'b1;
                    tx_n       = 1'b0;
                end
            end
            e_start_bit: begin
                if (bit_done) begin
                    state_n = e_data_bits;
                    tx_n    = shift_r[0];
                end
            end
            e_data_bits: begin
                if (bit_done) begin
                    if (data_cnt_r == last_data_lp) begin
                        if (parity_bit_p != 0) begin
                            state_n = e_parity_bit;
                            tx_n    = parity_r;
                        end else begin
                            state_n = e_stop_bit;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        shift_n    = shift_r >> 1;
                        data_cnt_n = data_cnt_r + data_cnt_width_lp'(1);
                        tx_n       = shift_r[1];
                    end
                end
            end
            e_parity_bit: begin
                if (bit_done) begin
                    state_n = e_stop_bit;
                    tx_n    = 1'b1;
                end
            end
            e_stop_bit: begin
                if (bit_done) begin
                    if (stop_last) begin
                        state_n = e_idle;
                        tx_n    = 1'b1;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = e_reset;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_reset;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_n;
            tx_r    <= tx_n;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_r    <= shift_n;
        data_cnt_r <= data_cnt_n;
        parity_r   <= parity_n;
        stop_cnt_r <= stop_cnt_n;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1, 8E1, 8O1 and 7N2 instances at 4 clocks/bit.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int cpb = 4;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b1;
    logic       tx_v_a  [4];
    logic [7:0] tx_i_a  [3];
    logic [6:0] tx_7;
    logic       tx_o_a  [4];
    logic       ready_a [4];
`ifdef UART_TX_BREAK_EN
    logic       brk = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    uart_tx #(.clk_per_bit_p(cpb), .data_bits_p(8), .parity_bit_p(0), .parity_odd_p(0), .stop_bits_p(1)) u_8n1 (
        .clk_i(clk_i), .reset_i(reset_i), .tx_v_i(tx_v_a[0]), .tx_i(tx_i_a[0]),
        .tx_ready_o(ready_a[0]), .tx_o(tx_o_a[0])
`ifdef UART_TX_BREAK_EN
       ,.break_i(brk)
`endif
    );

    uart_tx #(.clk_per_bit_p(cpb), .data_bits_p(8), .parity_bit_p(1), .parity_odd_p(0), .stop_bits_p(1)) u_8e1 (
        .clk_i(clk_i), .reset_i(reset_i), .tx_v_i(tx_v_a[1]), .tx_i(tx_i_a[1]),
        .tx_ready_o(ready_a[1]), .tx_o(tx_o_a[1])
`ifdef UART_TX_BREAK_EN
       ,.break_i(brk)
`endif
    );

    uart_tx #(.clk_per_bit_p(cpb), .data_bits_p(8), .parity_bit_p(1), .parity_odd_p(1), .stop_bits_p(1)) u_8o1 (
        .clk_i(clk_i), .reset_i(reset_i), .tx_v_i(tx_v_a[2]), .tx_i(tx_i_a[2]),
        .tx_ready_o(ready_a[2]), .tx_o(tx_o_a[2])
`ifdef UART_TX_BREAK_EN
       ,.break_i(brk)
`endif
    );

    uart_tx #(.clk_per_bit_p(cpb), .data_bits_p(7), .parity_bit_p(0), .parity_odd_p(0), .stop_bits_p(2)) u_7n2 (
        .clk_i(clk_i), .reset_i(reset_i), .tx_v_i(tx_v_a[3]), .tx_i(tx_7),
        .tx_ready_o(ready_a[3]), .tx_o(tx_o_a[3])
`ifdef UART_TX_BREAK_EN
       ,.break_i(brk)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Present a word at a negedge; returns at the negedge of the first frame cycle.
    task automatic send(input int idx, input logic [7:0] w, input bit keep_v);
        chk($sformatf("ready_before_send%0d", idx), 16'(ready_a[idx]), 16'd1);
        tx_v_a[idx] = 1'b1;
        if (idx == 3) tx_7 = w[6:0];
        else          tx_i_a[idx] = w;
        @(negedge clk_i);
        if (!keep_v) tx_v_a[idx] = 1'b0;
    endtask

    // bits[k] is the k-th bit on the line (bit 0 = start). Checks cycles
    // from_c..to_c-1 (to_c < 0 means the whole frame), then optionally the
    // idle cycle that follows the frame.
    task automatic check_frame(input int idx, input string tag, input logic [11:0] bits,
                               input int nb, input int from_c, input int to_c,
                               input int poke_at, input logic [7:0] poke_val,
                               input logic poke_v, input bit end_chk);
        int last;
        last = (to_c < 0) ? nb * cpb : to_c;
        for (int c = from_c; c < last; c++) begin
            if (c == poke_at) begin
                tx_i_a[idx] = poke_val;
                tx_v_a[idx] = poke_v;
            end
            chk($sformatf("%s_bit%0d_c%0d", tag, c / cpb, c), 16'(tx_o_a[idx]), 16'(bits[c / cpb]));
            chk($sformatf("%s_rdy_c%0d", tag, c), 16'(ready_a[idx]), 16'd0);
            @(negedge clk_i);
        end
        if (end_chk) begin
            chk({tag, "_end_rdy"}, 16'(ready_a[idx]), 16'd1);
            chk({tag, "_end_tx"}, 16'(tx_o_a[idx]), 16'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tx_v_a[i] = 1'b0;
        for (int i = 0; i < 3; i++) tx_i_a[i] = 8'h00;
        tx_7 = 7'h00;

        // reset held across 4 rising edges
        repeat (3) begin
            @(negedge clk_i);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rst_tx%0d", i), 16'(tx_o_a[i]), 16'd1);
                chk($sformatf("rst_rdy%0d", i), 16'(ready_a[i]), 16'd0);
            end
        end
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst1_rdy", 16'(ready_a[0]), 16'd0);
        chk("post_rst1_tx", 16'(tx_o_a[0]), 16'd1);
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_rst2_rdy%0d", i), 16'(ready_a[i]), 16'd1);
            chk($sformatf("post_rst2_tx%0d", i), 16'(tx_o_a[i]), 16'd1);
        end

        // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1
        send(0, 8'hA5, 1'b0);
        check_frame(0, "8n1_a5", 12'b00_1101001010, 10, 0, -1, -1, 8'h00, 1'b0, 1'b1);

        // 8E1 / 8O1 0xA5 (four ones): parity 0 / 1
        send(1, 8'hA5, 1'b0);
        check_frame(1, "8e1_a5", 12'b0_1010100101_0, 11, 0, -1, -1, 8'h00, 1'b0, 1'b1);
        send(2, 8'hA5, 1'b0);
        check_frame(2, "8o1_a5", 12'b0_1110100101_0, 11, 0, -1, -1, 8'h00, 1'b0, 1'b1);
        // 8E1 0x01: parity 1
        send(1, 8'h01, 1'b0);
        check_frame(1, "8e1_01", 12'b0_1100000001_0, 11, 0, -1, -1, 8'h00, 1'b0, 1'b1);

        // 7N2 0x55: data 1,0,1,0,1,0,1 then two stop bits, 40 cycles
        send(3, 8'h55, 1'b0);
        check_frame(3, "7n2_55", 12'b00_1110101010, 10, 0, -1, -1, 8'h00, 1'b0, 1'b1);

        // back-to-back: 0x00 then 0xFF with tx_v held; tx_i changes mid-frame
        send(0, 8'h00, 1'b1);
        check_frame(0, "b2b_00", 12'b00_1000000000, 10, 0, -1, 5, 8'hFF, 1'b1, 1'b1);
        @(negedge clk_i);
        check_frame(0, "b2b_ff", 12'b00_1111111110, 10, 0, -1, 10, 8'h5A, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("b2b_no_third_tx", 16'(tx_o_a[0]), 16'd1);
        chk("b2b_no_third_rdy", 16'(ready_a[0]), 16'd1);

        // reset in cycle 10 of a frame, then a fresh 0x3C frame
        send(0, 8'hA5, 1'b0);
        check_frame(0, "rst_mid", 12'b00_1101001010, 10, 0, 10, -1, 8'h00, 1'b0, 1'b0);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_tx", 16'(tx_o_a[0]), 16'd1);
        chk("rst_mid_rdy", 16'(ready_a[0]), 16'd0);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_rdy_back", 16'(ready_a[0]), 16'd1);
        send(0, 8'h3C, 1'b0);
        check_frame(0, "after_rst_3c", 12'b00_1001111000, 10, 0, -1, -1, 8'h00, 1'b0, 1'b1);

`ifdef UART_TX_BREAK_EN
        // break raised mid-frame: frame completes, then the line is held low
        send(0, 8'h3C, 1'b0);
        check_frame(0, "brk_3c", 12'b00_1001111000, 10, 0, 10, -1, 8'h00, 1'b0, 1'b0);
        brk = 1'b1;
        check_frame(0, "brk_3c", 12'b00_1001111000, 10, 10, -1, -1, 8'h00, 1'b0, 1'b0);
        chk("brk_idle0_tx", 16'(tx_o_a[0]), 16'd1);
        chk("brk_idle0_rdy", 16'(ready_a[0]), 16'd0);
        tx_v_a[0] = 1'b1;
        tx_i_a[0] = 8'hFF;
        repeat (3) begin
            @(negedge clk_i);
            chk("brk_hold_tx", 16'(tx_o_a[0]), 16'd0);
            chk("brk_hold_rdy", 16'(ready_a[0]), 16'd0);
        end
        tx_v_a[0] = 1'b0;
        brk = 1'b0;
        #1;
        chk("brk_drop_rdy", 16'(ready_a[0]), 16'd1);
        @(negedge clk_i);
        chk("brk_drop_tx", 16'(tx_o_a[0]), 16'd1);
        chk("brk_drop_rdy2", 16'(ready_a[0]), 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
